// File: rtl/value_change_logger.sv
// Samples a data bus and an integer bus each enabled clock and queues every value change
// as a {timestamp, channel, value} entry, drained through a first-word fall-through port.
module value_change_logger #(
  parameter int DATA_W = 4,
  parameter int INT_W  = 32,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [INT_W-1:0]           ival_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W-1:0]            out_ts,
  output logic                       out_chan,
  output logic [INT_W-1:0]           out_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] UNPRIMED = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;

  logic [0:0]        state;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] prev_data;
  logic [INT_W-1:0]  prev_ival;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic [TS_W-1:0]   mem_ts    [DEPTH];
  logic              mem_chan  [DEPTH];
  logic [INT_W-1:0]  mem_value [DEPTH];

  logic              ev0, ev1, wr0, wr1, drop, pop;
  logic [CW-1:0]     space;
  logic [CW-1:0]     pushes;
  logic [INT_W-1:0]  data_ext;

  // Event detection and in-order admission against the space left after this edge's pop.
  always_comb begin
    data_ext = INT_W'(data_in);
    ev0      = en && ((state == UNPRIMED) || (data_in != prev_data));
    ev1      = en && ((state == UNPRIMED) || (ival_in != prev_ival));
    pop      = (count != '0) && out_ready;
    space    = DEPTH_C - count + CW'(pop);
    wr0      = ev0 && (space != '0);
    wr1      = ev1 && (space > CW'(wr0));
    drop     = (ev0 && !wr0) || (ev1 && !wr1);
    pushes   = CW'(wr0) + CW'(wr1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNPRIMED;
      ts        <= '0;
      prev_data <= '0;
      prev_ival <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (en) begin
        state     <= RUN;
        ts        <= ts + TS_W'(1);
        prev_data <= data_in;
        prev_ival <= ival_in;
      end
      wr_ptr <= wr_ptr + AW'(pushes);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + pushes - CW'(pop);
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  // Storage is not reset; a full FIFO popping this edge may overwrite the slot being read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0 || wr1) begin
        mem_ts[wr_ptr]    <= ts;
        mem_chan[wr_ptr]  <= !wr0;
        mem_value[wr_ptr] <= wr0 ? data_ext : ival_in;
      end
      if (wr0 && wr1) begin
        mem_ts[wr_ptr + AW'(1)]    <= ts;
        mem_chan[wr_ptr + AW'(1)]  <= 1'b1;
        mem_value[wr_ptr + AW'(1)] <= ival_in;
      end
    end
  end

  always_comb begin
    out_valid = (count != '0);
    out_ts    = out_valid ? mem_ts[rd_ptr]    : '0;
    out_chan  = out_valid ? mem_chan[rd_ptr]  : 1'b0;
    out_value = out_valid ? mem_value[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_value_change_logger.sv
// Drives directed and random traffic into value_change_logger and compares every cycle
// against a queue-based reference model of the logging rules.
module tb_value_change_logger;

  localparam int DATA_W = 4;
  localparam int INT_W  = 32;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst, en, out_ready, clr_ovf;
  logic [DATA_W-1:0] data_in;
  logic [INT_W-1:0]  ival_in;
  logic              out_valid, out_chan, overflow;
  logic [TS_W-1:0]   out_ts;
  logic [INT_W-1:0]  out_value;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    int unsigned ts;
    int unsigned chan;
    longint unsigned value;
  } entry_t;

  entry_t          mq[$];
  int unsigned     m_ts;
  bit              m_primed;
  bit              m_ovf;
  longint unsigned m_pd, m_pi;

  int tests  = 0;
  int errors = 0;

  value_change_logger #(.DATA_W(DATA_W), .INT_W(INT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .ival_in(ival_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_chan(out_chan),
    .out_value(out_value), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint unsigned obs, input longint unsigned exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one clock edge expressed as queue operations.
  task automatic modelStep();
    entry_t e;
    bit drop;
    if (rst) begin
      mq.delete();
      m_ts = 0; m_primed = 0; m_ovf = 0; m_pd = 0; m_pi = 0;
      return;
    end
    drop = 0;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (en) begin
      if (!m_primed || data_in != m_pd) begin
        e.ts = m_ts; e.chan = 0; e.value = data_in;
        if (mq.size() < DEPTH) mq.push_back(e); else drop = 1;
      end
      if (!m_primed || ival_in != m_pi) begin
        e.ts = m_ts; e.chan = 1; e.value = ival_in;
        if (mq.size() < DEPTH) mq.push_back(e); else drop = 1;
      end
      m_pd = data_in; m_pi = ival_in; m_primed = 1;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  task automatic checkAll();
    checkOutput("count", count, mq.size());
    checkOutput("out_valid", out_valid, mq.size() != 0);
    checkOutput("overflow", overflow, m_ovf);
    if (mq.size() != 0) begin
      checkOutput("out_ts", out_ts, mq[0].ts);
      checkOutput("out_chan", out_chan, mq[0].chan);
      checkOutput("out_value", out_value, mq[0].value);
    end else begin
      checkOutput("out_ts_zero", out_ts, 0);
      checkOutput("out_chan_zero", out_chan, 0);
      checkOutput("out_value_zero", out_value, 0);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input int unsigned d, input int unsigned iv,
                               input bit rdy, input bit clr);
    rst = r; en = e; data_in = DATA_W'(d); ival_in = iv; out_ready = rdy; clr_ovf = clr;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1; en = 0; data_in = 0; ival_in = 0; out_ready = 0; clr_ovf = 0;
    #1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_count", count, 0);

    // Priming edge logs both channels at ts 0
    applyStimulus(0, 1, 4, 4, 0, 0);
    checkOutput("prime_count", count, 2);
    checkOutput("prime_head_chan", out_chan, 0);
    applyStimulus(0, 1, 4, 4, 0, 0);
    applyStimulus(0, 1, 5, 4, 0, 0);
    checkOutput("single_change_count", count, 3);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 5, 4, 1, 0);

    // Simultaneous change on both channels, drained in order
    applyStimulus(0, 1, 5, 4, 0, 0);
    applyStimulus(0, 1, 5, 4, 0, 0);
    applyStimulus(0, 1, 7, 10, 0, 0);
    checkOutput("dual_head_chan", out_chan, 0);
    checkOutput("dual_head_val", out_value, 7);
    applyStimulus(0, 0, 7, 10, 1, 0);
    checkOutput("dual_second_val", out_value, 10);
    applyStimulus(0, 0, 7, 10, 1, 0);

    // Fill to capacity, overflow on the 9th, clear, then clear colliding with a drop
    for (int k = 0; k < 9; k++) applyStimulus(0, 1, (k % 2) ? 7 : 3, 10, 0, 0);
    checkOutput("full_count", count, DEPTH);
    checkOutput("full_ovf", overflow, 1);
    applyStimulus(0, 0, 3, 10, 0, 1);
    checkOutput("ovf_cleared", overflow, 0);
    applyStimulus(0, 1, 9, 10, 0, 1);
    checkOutput("ovf_clr_vs_drop", overflow, 1);
    applyStimulus(0, 0, 9, 10, 0, 1);

    // Full FIFO with concurrent pop: one change fits, two changes drop channel 1
    applyStimulus(0, 1, 2, 10, 1, 0);
    checkOutput("full_pop_push_count", count, DEPTH);
    checkOutput("full_pop_push_ovf", overflow, 0);
    applyStimulus(0, 1, 6, 11, 1, 0);
    checkOutput("full_pop_dual_ovf", overflow, 1);

    // Drain, then wrap the timestamp and hold it with en low
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 6, 11, 1, 1);
    for (int k = 0; k < 16; k++) applyStimulus(0, 1, 6, 11, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 12, 0, 0);
    applyStimulus(0, 1, 1, 11, 0, 0);
    checkOutput("wrapped_ts", out_ts, m_ts == 0 ? 15 : m_ts - 1);

    // Mid-operation reset discards queued entries and re-primes
    applyStimulus(0, 1, 2, 13, 0, 0);
    applyStimulus(0, 1, 3, 14, 0, 0);
    applyStimulus(1, 0, 3, 14, 0, 0);
    checkOutput("rst_clears_valid", out_valid, 0);
    applyStimulus(0, 1, 3, 14, 0, 0);
    checkOutput("reprime_count", count, 2);

    // Randomised traffic
    for (int k = 0; k < 3000; k++)
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 1), ($urandom_range(0, 9) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
